decode_queue: RTL and testbench
===============================

# decode_queue

Registered, parametrised RV32I instruction decoder with an in-order decode queue between fetch and execute. Accepts full 32-bit instruction words with PC on a valid/ready handshake and decodes them into the 15-bit control word plus register and funct fields. It buffers up to `DEPTH` decoded entries, supports pipeline flush, and keeps a saturating illegal-instruction counter. Optional M-extension decode is selectable at compile time.

## Interface
- `XLEN`, 32: PC width.
- `DEPTH`, 2: queue entries; must be a power of two and at least 2.
- `CNT_W`, 8: illegal-counter width.

- `i_clk`  in  1  clock.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_inValid`  in  1  upstream instruction valid.
- `o_inReady`  out  1  queue can accept.
- `i_instr`  in  32  instruction word.
- `i_pc`  in  XLEN  instruction PC.
- `i_flush`  in  1  discard all queued entries and the current input.
- `o_outValid`  out  1  head entry valid.
- `i_outReady`  in  1  downstream consumes head.
- `o_ctrlSigs`  out  15  head control word.
- `o_pc`  out  XLEN  head PC.
- `o_rd`, `o_rs1`, `o_rs2`  out  5 each  register fields from the instruction at bits [11:7], [19:15] and [24:20].
- `o_funct3`  out  3  head funct3.
- `i_cntClr`  in  1  clear illegal counter.
- `o_illegalCnt`  out  CNT_W  saturating illegal count.

## Operation
- Control word layout, MSB to LSB:
  - `MULDIV` (bit 14), `BRK`, `SYS`, `ALU_OP[4:0]`.
  - `EXEC_A` (PC=1 / REG=0), `EXEC_B` (IMM=1 / REG=0).
  - `MEM_W`, `REG_W`, `MEM2REG`, `BRA`, `JMP`.
  - `ALU_OP` encodings come from `types.vh`.
- Decode is combinational on `i_instr`. The entry is written into the queue on accept, defined as `i_inValid & o_inReady & ~i_flush`.
- Decode rules:
  - LUI: `PASSB`, B=IMM, REG_W.
  - AUIPC: `ADD`, A=PC, B=IMM, REG_W.
  - JAL and JALR: `ADD4A`, A=PC, REG_W, JMP.
  - Branches:
    - funct3 000/001/100/101/110/111 map to EQ/NEQ/SLT/SGTE/SLTU/SGTEU.
    - A and B both REG; BRA set.
  - Loads:
    - Valid funct3 values are 000, 001, 010, 100 and 101.
    - `ADD`, B=IMM, REG_W, MEM2REG.
  - Stores:
    - Valid funct3 values are 000, 001 and 010.
    - `ADD`, B=IMM, MEM_W.
  - OP-IMM:
    - funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL-or-SRA/OR/AND; `instr[30]` selects SRA.
    - B=IMM, REG_W.
  - OP:
    - Same funct3 map as OP-IMM; `instr[30]` selects SUB and SRA.
    - A and B both REG, REG_W.
  - MISC-MEM with funct3 000: `ADD`, B=IMM.
  - SYSTEM with funct3 000: SYS set, `ADD`, B=IMM.
  - Any other encoding decodes as INVALID: BRK=1, `ADD`, all other bits 0.
  - `instr[1:0]` ≠ 11 is INVALID.
- Queue behaviour:
  - FIFO with read and write pointers of log2(`DEPTH`)+1 bits.
  - Full when the pointers are equal except for the MSB; empty when fully equal.
  - `o_inReady` = `~full | i_outReady`, so push and pop can happen in the same cycle when full.
  - Pop occurs on `o_outValid & i_outReady`.
  - `o_outValid` = `~empty`. Head outputs are driven directly from storage at the read pointer.
- Flush:
  - Resets both pointers to 0 in the next cycle.
  - The input in the flush cycle is dropped and not counted.
  - A pop in the flush cycle still completes at the interface.
- Illegal counter:
  - Increments on each accepted INVALID entry and saturates at all-ones.
  - `i_cntClr` has priority: if increment and clear occur together, the counter becomes 0.

## Timing
- Reset values: pointers 0, `o_outValid`=0, `o_inReady`=1, `o_illegalCnt`=0.
- Reset values with the queue empty (storage not reset; the bench must not check these): `o_ctrlSigs`, `o_pc`, `o_rd`, `o_rs1`, `o_rs2`, `o_funct3`.
- Latency: an entry accepted in cycle N appears on `o_outValid` in cycle N+1. There is no combinational input-to-output bypass.
- Throughput: 1 instruction per cycle with `i_outReady` held high.
- `o_inReady` and `o_outValid` depend only on registered state and `i_outReady`. No path exists from `i_inValid` to `o_inReady`.
- `o_illegalCnt` updates in the cycle after the accept.
- Reset asserted mid-stream empties the queue asynchronously and clears the counter.

## Configuration
- `DECODE_QUEUE_MULDIV_EN` defined:
  - An OP instruction with funct7=0000001 decodes as MULDIV=1, REG_W=1, A and B both REG, `ALU_OP`=`ADD`.
  - funct3 is passed on `o_funct3` for the divider/multiplier.
- Macro undefined:
  - Those encodings are INVALID, and bit 14 is constant 0.

## Test plan
- Reset, then push 0x00500093 (ADDI x1,x0,5) at PC 0x100 → one cycle later `o_outValid`=1, `ALU_OP`=ADD, EXEC_B=1, REG_W=1, `o_rd`=1, `o_pc`=0x100.
- Push 0x402081B3 (SUB x3,x1,x2) then 0x00000073 (ECALL) back to back with `i_outReady`=1 → SUB with A/B both REG, REG_W=1, followed by SYS=1, `o_illegalCnt`=0.
- Hold `i_outReady`=0 and push `DEPTH`+1 words → `o_inReady`=0 after `DEPTH` accepts. Then raise `i_outReady` with `i_inValid`=1 → push and pop occur in the same cycle, and order is preserved.
- Push 0x00000000 three times, and on the third accept assert `i_cntClr` → BRK=1 on each entry; the counter reads 2, then 0. With `CNT_W`=2, after 5 illegal accepts the counter saturates at 3.
- Fill the queue, assert `i_flush` together with a valid input → next cycle `o_outValid`=0, and the flushed input never appears.
- Push 0x022081B3 (MUL x3,x1,x2) → with the macro defined: MULDIV=1, `o_funct3`=0. Without the macro: BRK=1 and the counter increments.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decoder feeding an in-order decode queue with flush and a saturating illegal counter.
// Define DECODE_QUEUE_MULDIV_EN to decode the M-extension OP encodings.
module decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_inValid,
    output logic             o_inReady,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_flush,
    output logic             o_outValid,
    input  logic             i_outReady,
    output logic [14:0]      o_ctrlSigs,
    output logic [XLEN-1:0]  o_pc,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [2:0]       o_funct3,
    input  logic             i_cntClr,
    output logic [CNT_W-1:0] o_illegalCnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_PASSB = 5'd10,
        ALU_ADD4A = 5'd11,
        ALU_EQ    = 5'd12,
        ALU_NEQ   = 5'd13,
        ALU_SGTE  = 5'd14,
        ALU_SGTEU = 5'd15
    } alu_op_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    alu_op_e alu_op;
    logic    exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp, sys, muldiv, illegal;
    logic [14:0] dec_ctrl;

    always_comb begin
        alu_op  = ALU_ADD;
        exec_a  = 1'b0;
        exec_b  = 1'b0;
        mem_w   = 1'b0;
        reg_w   = 1'b0;
        mem2reg = 1'b0;
        bra     = 1'b0;
        jmp     = 1'b0;
        sys     = 1'b0;
        muldiv  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASSB;
                exec_b = 1'b1;
                reg_w  = 1'b1;
            end
            OPC_AUIPC: begin
                exec_a = 1'b1;
                exec_b = 1'b1;
                reg_w  = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                alu_op = ALU_ADD4A;
                exec_a = 1'b1;
                reg_w  = 1'b1;
                jmp    = 1'b1;
            end
            OPC_BRANCH: begin
                bra = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_EQ;
                    3'b001:  alu_op = ALU_NEQ;
                    3'b100:  alu_op = ALU_SLT;
                    3'b101:  alu_op = ALU_SGTE;
                    3'b110:  alu_op = ALU_SLTU;
                    3'b111:  alu_op = ALU_SGTEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                exec_b  = 1'b1;
                reg_w   = 1'b1;
                mem2reg = 1'b1;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                exec_b  = 1'b1;
                mem_w   = 1'b1;
                illegal = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OPC_OPIMM, OPC_OP: begin
                reg_w  = 1'b1;
                exec_b = (opcode == OPC_OPIMM);
                case (funct3)
                    3'b000:  alu_op = (opcode == OPC_OP && i_instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = i_instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
                if (opcode == OPC_OP && funct7 == 7'b0000001) begin
                    alu_op = ALU_ADD;
`ifdef DECODE_QUEUE_MULDIV_EN
                    muldiv = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end
            end
            OPC_MISC: begin
                exec_b  = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                sys     = 1'b1;
                exec_b  = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Any invalid encoding collapses to a bare BRK + ADD word, whatever the partial decode set.
    assign dec_ctrl = illegal ? {2'b01, 1'b0, ALU_ADD, 7'b0}
                              : {muldiv, 1'b0, sys, alu_op, exec_a, exec_b,
                                 mem_w, reg_w, mem2reg, bra, jmp};

    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, accept, pop;

    logic [14:0]     ctrl_mem   [DEPTH];
    logic [XLEN-1:0] pc_mem     [DEPTH];
    logic [4:0]      rd_mem     [DEPTH];
    logic [4:0]      rs1_mem    [DEPTH];
    logic [4:0]      rs2_mem    [DEPTH];
    logic [2:0]      funct3_mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign o_inReady  = ~full | i_outReady;
    assign o_outValid = ~empty;
    assign accept     = i_inValid & o_inReady & ~i_flush;
    assign pop        = o_outValid & i_outReady;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            ctrl_mem[wr_ptr[AW-1:0]]   <= dec_ctrl;
            pc_mem[wr_ptr[AW-1:0]]     <= i_pc;
            rd_mem[wr_ptr[AW-1:0]]     <= i_instr[11:7];
            rs1_mem[wr_ptr[AW-1:0]]    <= i_instr[19:15];
            rs2_mem[wr_ptr[AW-1:0]]    <= i_instr[24:20];
            funct3_mem[wr_ptr[AW-1:0]] <= funct3;
        end
    end

    assign o_ctrlSigs = ctrl_mem[rd_ptr[AW-1:0]];
    assign o_pc       = pc_mem[rd_ptr[AW-1:0]];
    assign o_rd       = rd_mem[rd_ptr[AW-1:0]];
    assign o_rs1      = rs1_mem[rd_ptr[AW-1:0]];
    assign o_rs2      = rs2_mem[rd_ptr[AW-1:0]];
    assign o_funct3   = funct3_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_illegalCnt <= '0;
        end else if (i_cntClr) begin
            o_illegalCnt <= '0;
        end else if (accept && illegal && o_illegalCnt != '1) begin
            o_illegalCnt <= o_illegalCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed instruction words with hand-decoded expectations.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready, cnt_clr;
    logic [31:0] instr, pc;

    logic        in_ready, out_valid;
    logic [14:0] ctrl;
    logic [31:0] o_pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [7:0]  cnt;

    logic        s_in_ready, s_out_valid;
    logic [14:0] s_ctrl;
    logic [31:0] s_pc;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [2:0]  s_f3;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    decode_queue #(.XLEN(32), .DEPTH(2), .CNT_W(8)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_inValid(in_valid), .o_inReady(in_ready),
        .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_outValid(out_valid),
        .i_outReady(out_ready), .o_ctrlSigs(ctrl), .o_pc(o_pc), .o_rd(rd),
        .o_rs1(rs1), .o_rs2(rs2), .o_funct3(f3), .i_cntClr(cnt_clr), .o_illegalCnt(cnt)
    );

    decode_queue #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rstn(rst_n), .i_inValid(in_valid), .o_inReady(s_in_ready),
        .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_outValid(s_out_valid),
        .i_outReady(out_ready), .o_ctrlSigs(s_ctrl), .o_pc(s_pc), .o_rd(s_rd),
        .o_rs1(s_rs1), .o_rs2(s_rs2), .o_funct3(s_f3), .i_cntClr(cnt_clr), .o_illegalCnt(s_cnt)
    );

    typedef struct {
        logic [31:0] ins;
        logic [14:0] ctrl;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } vec_t;

    typedef struct {
        logic [14:0] ctrl;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } exp_t;

    localparam int V_ADDI = 0, V_SUB = 1, V_ECALL = 2, V_ZERO = 3, V_MUL = 4, V_LUI = 5,
                   V_BEQ = 6, V_LW = 7, V_SW = 8, V_JAL = 9, V_SRAI = 10, V_BADBR = 11, V_C16 = 12;

    vec_t vt [13];
    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   last_acc;

    function automatic vec_t mk(input logic [31:0] ins, input logic [14:0] c,
                                input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] fn);
        vec_t v;
        v.ins = ins; v.ctrl = c; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = fn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic step(input bit v, input int idx, input logic [31:0] p,
                        input bit fl, input bit clr, input bit ordy);
        exp_t e;
        in_valid = v; instr = vt[idx].ins; pc = p; flush = fl; cnt_clr = clr; out_ready = ordy;
        #1;
        last_acc = v && in_ready && !fl;
        if (last_acc) begin
            e.ctrl = vt[idx].ctrl; e.pc = p; e.rd = vt[idx].rd;
            e.rs1 = vt[idx].rs1; e.rs2 = vt[idx].rs2; e.f3 = vt[idx].f3;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, V_ADDI, 32'h0, 1'b0, 1'b0, ordy);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", o_pc);
            end else begin
                e = sb.pop_front();
                chk("head_ctrl", {17'b0, ctrl}, {17'b0, e.ctrl});
                chk("head_pc", o_pc, e.pc);
                chk("head_rd", {27'b0, rd}, {27'b0, e.rd});
                chk("head_rs1", {27'b0, rs1}, {27'b0, e.rs1});
                chk("head_rs2", {27'b0, rs2}, {27'b0, e.rs2});
                chk("head_funct3", {29'b0, f3}, {29'b0, e.f3});
            end
        end
        if (rst_n && flush) sb.delete();
    end

    initial begin
        vt[V_ADDI]  = mk(32'h00500093, 15'h0028, 5'd1, 5'd0, 5'd5, 3'd0);
        vt[V_SUB]   = mk(32'h402081B3, 15'h0088, 5'd3, 5'd1, 5'd2, 3'd0);
        vt[V_ECALL] = mk(32'h00000073, 15'h1020, 5'd0, 5'd0, 5'd0, 3'd0);
        vt[V_ZERO]  = mk(32'h00000000, 15'h2000, 5'd0, 5'd0, 5'd0, 3'd0);
`ifdef DECODE_QUEUE_MULDIV_EN
        vt[V_MUL]   = mk(32'h022081B3, 15'h4008, 5'd3, 5'd1, 5'd2, 3'd0);
`else
        vt[V_MUL]   = mk(32'h022081B3, 15'h2000, 5'd3, 5'd1, 5'd2, 3'd0);
`endif
        vt[V_LUI]   = mk(32'h123450B7, 15'h0528, 5'd1, 5'd8, 5'd3, 3'd5);
        vt[V_BEQ]   = mk(32'h00208463, 15'h0602, 5'd8, 5'd1, 5'd2, 3'd0);
        vt[V_LW]    = mk(32'h00812283, 15'h002C, 5'd5, 5'd2, 5'd8, 3'd2);
        vt[V_SW]    = mk(32'h00512623, 15'h0030, 5'd12, 5'd2, 5'd5, 3'd2);
        vt[V_JAL]   = mk(32'h008000EF, 15'h05C9, 5'd1, 5'd0, 5'd8, 3'd0);
        vt[V_SRAI]  = mk(32'h4030D093, 15'h03A8, 5'd1, 5'd1, 5'd3, 3'd5);
        vt[V_BADBR] = mk(32'h0020A463, 15'h2000, 5'd8, 5'd1, 5'd2, 3'd2);
        vt[V_C16]   = mk(32'h00000001, 15'h2000, 5'd0, 5'd0, 5'd0, 3'd0);

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        instr = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outValid", {31'b0, out_valid}, 32'd0);
        chk("rst_inReady", {31'b0, in_ready}, 32'd1);
        chk("rst_cnt", {24'b0, cnt}, 32'd0);
        chk("rst_sat_cnt", {30'b0, s_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-entry latency, then back-to-back streaming
        step(1'b1, V_ADDI, 32'h100, 1'b0, 1'b0, 1'b0);
        chk("latency_outValid", {31'b0, out_valid}, 32'd1);
        step(1'b1, V_SUB, 32'h104, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_ECALL, 32'h108, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        chk("cnt_after_ecall", {24'b0, cnt}, 32'd0);
        chk("drained_outValid", {31'b0, out_valid}, 32'd0);

        // fill with DEPTH+1 words, then simultaneous push/pop while full
        step(1'b1, V_LUI, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_BEQ, 32'h204, 1'b0, 1'b0, 1'b0);
        chk("full_inReady", {31'b0, in_ready}, 32'd0);
        step(1'b1, V_LW, 32'h208, 1'b0, 1'b0, 1'b0);
        chk("full_blocks_accept", {31'b0, last_acc}, 32'd0);
        step(1'b1, V_LW, 32'h208, 1'b0, 1'b0, 1'b1);
        chk("push_pop_accept", {31'b0, last_acc}, 32'd1);
        out_ready = 1'b0;
        #1;
        chk("still_full_inReady", {31'b0, in_ready}, 32'd0);
        step(1'b1, V_SW, 32'h20C, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_JAL, 32'h210, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_SRAI, 32'h214, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("stream_drained", {31'b0, out_valid}, 32'd0);

        // illegal counter, clear priority, saturation on the 2-bit instance
        step(1'b1, V_ZERO, 32'h300, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_ZERO, 32'h304, 1'b0, 1'b0, 1'b1);
        chk("cnt_two", {24'b0, cnt}, 32'd2);
        step(1'b1, V_ZERO, 32'h308, 1'b0, 1'b1, 1'b1);
        chk("cnt_clr_priority", {24'b0, cnt}, 32'd0);
        chk("sat_clr_priority", {30'b0, s_cnt}, 32'd0);
        step(1'b1, V_BADBR, 32'h30C, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_C16, 32'h310, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_ZERO, 32'h314, 1'b0, 1'b0, 1'b1);
        chk("cnt_three", {24'b0, cnt}, 32'd3);
        chk("sat_three", {30'b0, s_cnt}, 32'd3);
        step(1'b1, V_ZERO, 32'h318, 1'b0, 1'b0, 1'b1);
        step(1'b1, V_ZERO, 32'h31C, 1'b0, 1'b0, 1'b1);
        chk("cnt_five", {24'b0, cnt}, 32'd5);
        chk("sat_held", {30'b0, s_cnt}, 32'd3);
        step(1'b0, V_ADDI, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("cnt_cleared", {24'b0, cnt}, 32'd0);
        chk("sat_cleared", {30'b0, s_cnt}, 32'd0);
        idle(2, 1'b1);

        // flush a full queue with a valid illegal input
        step(1'b1, V_SUB, 32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_ADDI, 32'h404, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_ZERO, 32'h408, 1'b1, 1'b0, 1'b0);
        chk("flush_outValid", {31'b0, out_valid}, 32'd0);
        chk("flush_inReady", {31'b0, in_ready}, 32'd1);
        chk("flush_cnt", {24'b0, cnt}, 32'd0);
        idle(3, 1'b1);

        // flush with a pop in the same cycle: head still delivered
        step(1'b1, V_LUI, 32'h500, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_BEQ, 32'h504, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_ZERO, 32'h508, 1'b1, 1'b0, 1'b1);
        chk("flush_pop_outValid", {31'b0, out_valid}, 32'd0);
        chk("flush_pop_cnt", {24'b0, cnt}, 32'd0);
        idle(2, 1'b1);

        // M-extension encoding
        step(1'b1, V_MUL, 32'h600, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
`ifdef DECODE_QUEUE_MULDIV_EN
        chk("mul_cnt", {24'b0, cnt}, 32'd0);
`else
        chk("mul_cnt", {24'b0, cnt}, 32'd1);
`endif

        // asynchronous reset mid-stream
        step(1'b1, V_ZERO, 32'h700, 1'b0, 1'b0, 1'b0);
        step(1'b1, V_SRAI, 32'h704, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outValid", {31'b0, out_valid}, 32'd0);
        chk("midrst_inReady", {31'b0, in_ready}, 32'd1);
        chk("midrst_cnt", {24'b0, cnt}, 32'd0);
        chk("midrst_sat_cnt", {30'b0, s_cnt}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2, 1'b1);
        chk("post_rst_outValid", {31'b0, out_valid}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
